alu_mdu_seq: RTL and testbench
==============================

Name: alu_mdu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle execute ALU.
- Adds the full RV32I integer op set plus the M-extension: multiply via an iterative shift-add unit, divide via an iterative restoring-divide unit.
- Sits in the multi-cycle core's execute stage behind a valid/ready interface; the core stalls on in_ready/out_valid.
- Keeps the legacy 4-bit AND/OR/ADD/SUB encodings, zero-extended to 5 bits.

Parameters:
- XLEN, 32, operand/result width; must be >= 8 and even.
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- op  input  5  operation code.
- a  input  XLEN  operand 1 (rs1).
- b  input  XLEN  operand 2 (rs2/imm).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  registered result.
- zero  output  1  ~|result; meaningful only while out_valid=1.

Behaviour:
- Op codes, basic group:
  - 00000 AND, 00001 OR, 00010 ADD, 00011 XOR, 00100 SLL, 00101 SRL, 00110 SUB, 00111 SRA, 01000 SLT, 01001 SLTU.
  - Shift amount is b[$clog2(XLEN)-1:0].
  - SLT/SLTU return 1 or 0.
  - ADD/SUB wrap modulo 2^XLEN; no flags other than zero.
- Op codes, M group:
  - 10000 MUL (low XLEN of product).
  - 10001 MULH (high XLEN, signed x signed).
  - 10010 MULHSU (high XLEN, signed a x unsigned b).
  - 10011 MULHU (high XLEN, unsigned x unsigned).
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU (RISC-V semantics; quotient truncates toward zero, remainder takes the dividend's sign).
- Any other code: accepted, result=0, latency 1.
- Handshake:
  - Request accepted on the rising edge where in_valid & in_ready.
  - op, a and b are captured at acceptance; later input changes are ignored.
  - Result is presented with out_valid=1 and held stable (result, zero) until the edge where out_valid & out_ready.
- State machine: IDLE, CALC, DONE.
  - in_ready = (state==IDLE).
  - IDLE: on accept of a basic/undefined op, compute and register the result -> DONE. On accept of an M op, load operand magnitudes, clear accumulator, counter=0 -> CALC.
  - CALC: one partial-product / trial-subtract step per cycle. After XLEN steps, apply sign fix-up and register the result -> DONE.
  - DONE: out_valid=1. On out_ready -> IDLE. out_ready is sampled only in DONE.
- Latency (acceptance edge to first cycle of out_valid):
  - Basic/undefined ops: 1 cycle.
  - M ops: exactly XLEN+1 cycles, for every op and operand value, including special cases.
- Throughput: at most one request per 2 cycles (accept, then DONE with out_ready=1).
- Special cases. These are still iterated (or the counter still runs) so latency stays fixed.
  - DIV/DIVU by zero: quotient = all ones.
  - REM/REMU by zero: remainder = a.
  - DIV overflow (a = -2^(XLEN-1), b = -1): quotient = a.
  - REM overflow: remainder = 0.
- Signed handling:
  - Operands are converted to magnitudes.
  - Result negated when signs differ (quotient/product) or when a is negative (remainder).
  - -2^(XLEN-1) magnitude must be handled without overflow; use an XLEN+1-bit internal width where needed.
- Reset:
  - rst_n low immediately forces state=IDLE, out_valid=0, result=0, counter=0 and internal operand/accumulator registers to 0.
  - in_ready=1 while in reset and after it.
  - Reset during CALC or DONE aborts the operation; no out_valid follows.
- No combinational path from in_valid/op/a/b to any output. in_ready and out_valid depend only on state.

Test Plan:
- ADD a=0x7FFFFFFF, b=0x00000001 -> out_valid one cycle after accept; result=0x80000000, zero=0. Then SUB a=b=0x5 -> result=0, zero=1.
- SRA a=0x80000000, b=0x0000001F -> 0xFFFFFFFF. SLTU a=0x1, b=0xFFFFFFFF -> 1. SLT on the same operands -> 0.
- MULH a=b=0x80000000 -> out_valid exactly 33 cycles after accept, result=0x40000000. MUL a=0xFFFFFFFF, b=0x3 -> 0xFFFFFFFD. MULHU on the same operands -> 0x00000002.
- DIV a=0x00000007, b=0 -> 0xFFFFFFFF. REM a=7, b=0 -> 7. DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM on the same operands -> 0. DIV a=-7, b=2 -> 0xFFFFFFFD. REM a=-7, b=2 -> 0xFFFFFFFF. Latency is 33 cycles in every case.
- Backpressure: out_ready held low 5 cycles in DONE -> result/zero stable, in_ready=0, new in_valid ignored. Result is consumed on the first out_ready edge, then in_ready=1 the next cycle.
- Pulse rst_n low during CALC (cycle 10 of a DIVU) -> out_valid stays 0, result=0, in_ready=1. A subsequent ADD 2+3 returns 5 with latency 1.

Source files
------------

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: handshaked execute unit with the RV32I integer ops plus the
// M extension. Basic ops finish in one cycle. Multiply uses an iterative
// shift-add unit and divide uses an iterative restoring divider; both take
// a fixed XLEN+1 cycles.
module alu_mdu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SH_W = $clog2(XLEN);

  localparam logic [4:0] OP_AND    = 5'b00000;
  localparam logic [4:0] OP_OR     = 5'b00001;
  localparam logic [4:0] OP_ADD    = 5'b00010;
  localparam logic [4:0] OP_XOR    = 5'b00011;
  localparam logic [4:0] OP_SLL    = 5'b00100;
  localparam logic [4:0] OP_SRL    = 5'b00101;
  localparam logic [4:0] OP_SUB    = 5'b00110;
  localparam logic [4:0] OP_SRA    = 5'b00111;
  localparam logic [4:0] OP_SLT    = 5'b01000;
  localparam logic [4:0] OP_SLTU   = 5'b01001;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [4:0]        op_q;
  logic [XLEN-1:0]   hi;        // product high half / partial remainder
  logic [XLEN-1:0]   lo;        // multiplier / dividend shifting into quotient
  logic [XLEN-1:0]   opnd;      // multiplicand / divisor magnitude
  logic [XLEN-1:0]   a_q;       // original dividend, returned by REM by zero
  logic              neg_q;     // negate the final magnitude
  logic              bz_q;      // divisor was zero
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              is_m;
  logic              last_step;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign zero      = ~|result_q;
  assign accept    = in_valid & in_ready;
  assign is_m      = (op[4:3] == 2'b10);
  assign last_step = (cnt == CNT_W'(XLEN - 1));

  // Single-cycle result for the basic group; undefined codes yield zero.
  logic [XLEN-1:0] basic_res;
  logic [SH_W-1:0] shamt;
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and no latch is inferred.
    basic_res = '0;
    shamt     = b[SH_W-1:0];
    case (op)
      OP_AND:  basic_res = a & b;
      OP_OR:   basic_res = a | b;
      OP_ADD:  basic_res = a + b;
      OP_XOR:  basic_res = a ^ b;
      OP_SLL:  basic_res = a << shamt;
      OP_SRL:  basic_res = a >> shamt;
      OP_SUB:  basic_res = a - b;
      OP_SRA:  basic_res = $signed(a) >>> shamt;
      OP_SLT:  basic_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: basic_res = {{(XLEN-1){1'b0}}, (a < b)};
      default: basic_res = '0;
    endcase
  end

  // Operand magnitudes and final sign for M ops. The magnitude of the most
  // negative value is 2^(XLEN-1), which still fits as an unsigned XLEN value.
  logic            sign_a, sign_b, neg_load;
  logic [XLEN-1:0] mag_a, mag_b;
  always_comb begin
    sign_a   = ((op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM)) & a[XLEN-1];
    sign_b   = ((op == OP_MULH) | (op == OP_DIV) | (op == OP_REM)) & b[XLEN-1];
    mag_a    = sign_a ? -a : a;
    mag_b    = sign_b ? -b : b;
    // Remainder follows the dividend's sign; quotient and product follow the xor.
    neg_load = (op == OP_REM) ? sign_a : (sign_a ^ sign_b);
  end

  // One shift-add or restoring trial-subtract step on the current registers.
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] diff;
  logic [XLEN-1:0] hi_n, lo_n;
  logic            unused_diff_bit;
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    rem_sh  = {hi, lo[XLEN-1]};
    diff    = {1'b0, rem_sh} - {2'b00, opnd};
    if (op_q[2]) begin
      if (!diff[XLEN+1]) begin
        hi_n = diff[XLEN-1:0];
        lo_n = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_n = rem_sh[XLEN-1:0];
        lo_n = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo[XLEN-1:1]};
    end
  end
  // A successful trial subtract always leaves a value below the divisor.
  assign unused_diff_bit = diff[XLEN];

  // Sign fix-up and special cases applied to the final step's outputs.
  logic [2*XLEN-1:0] mul_prod, mul_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, m_res;
  always_comb begin
    mul_prod = {hi_n, lo_n};
    mul_fix  = neg_q ? -mul_prod : mul_prod;
    quo_fix  = neg_q ? -lo_n : lo_n;
    rem_fix  = neg_q ? -hi_n : hi_n;
    case (op_q)
      OP_MUL:                       m_res = mul_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: m_res = mul_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              m_res = bz_q ? '1 : quo_fix;
      OP_REM, OP_REMU:              m_res = bz_q ? a_q : rem_fix;
      default:                      m_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> DONE for basic ops, IDLE -> CALC -> DONE for M ops.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)    state_nxt = is_m ? CALC : DONE;
      CALC: if (last_step) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, iterate in CALC, register the result.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every datapath register is cleared by reset, so an aborted
    // operation leaves no stale operand or partial result behind.
    if (!rst_n) begin
      cnt      <= '0;
      op_q     <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      a_q      <= '0;
      neg_q    <= 1'b0;
      bz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values, whatever the statement order.
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= op;
            if (is_m) begin
              hi    <= '0;
              lo    <= mag_a;
              opnd  <= mag_b;
              a_q   <= a;
              neg_q <= neg_load;
              bz_q  <= (b == '0);
              cnt   <= '0;
            end else begin
              result_q <= basic_res;
            end
          end
        end
        CALC: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt + CNT_W'(1);
          if (last_step) result_q <= m_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Testbench for alu_mdu_seq: directed vectors feed a scoreboard queue; a
// monitor checks result, zero and latency whenever out_valid is presented.
module tb_alu_mdu_seq;

  localparam int XLEN = 32;
  localparam int MLAT = XLEN + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] a, b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  alu_mdu_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] res;
    int          lat;
    int          acc;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   n_issued = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Waits for in_ready, presents one request for one edge, records the
  // expected response. Called and returns at posedge+1.
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_res, input int lat, input bit track);
    int   waited = 0;
    exp_t e;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: in_ready still 0 after %0d cycles", waited);
      return;
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    if (track) begin
      e.res = exp_res; e.lat = lat; e.acc = cyc; e.id = n_issued;
      sb_q.push_back(e);
    end
    n_issued++;
  endtask

  // Monitor: checks every presented output against the head of the queue.
  int   first_cyc = 0;
  bit   seen = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out_valid: got result 0x%08h with nothing outstanding", result);
      end else begin
        cur = sb_q[0];
        if (!seen) begin
          seen = 1'b1;
          first_cyc = cyc;
        end
        check($sformatf("result#%0d", cur.id), result, cur.res);
        check($sformatf("zero#%0d", cur.id), {31'b0, zero}, {31'b0, (cur.res == 32'h0)});
        if (out_ready) begin
          check($sformatf("latency#%0d", cur.id), first_cyc - cur.acc + 1, cur.lat);
          void'(sb_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int waited;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    #12;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic group, latency 1.
    issue(5'b00010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1, 1);
    issue(5'b00110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1, 1);
    issue(5'b00111, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1, 1);
    issue(5'b01001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1, 1);
    issue(5'b01000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1);
    issue(5'b00000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1, 1);
    issue(5'b00001, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1, 1);
    issue(5'b00011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1, 1);
    issue(5'b00100, 32'h0000_0001, 32'h0000_0025, 32'h0000_0020, 1, 1);
    issue(5'b00101, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1, 1);
    issue(5'b01010, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1, 1);
    issue(5'b11000, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0000, 1, 1);

    // Multiply group, latency XLEN+1.
    issue(5'b10001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MLAT, 1);
    issue(5'b10000, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, MLAT, 1);
    issue(5'b10011, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0002, MLAT, 1);
    issue(5'b10010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MLAT, 1);

    // Divide group including special cases, latency XLEN+1.
    issue(5'b10100, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, MLAT, 1);
    issue(5'b10110, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, MLAT, 1);
    issue(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, MLAT, 1);
    issue(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, MLAT, 1);
    issue(5'b10100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, MLAT, 1);
    issue(5'b10110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, MLAT, 1);
    issue(5'b10100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, MLAT, 1);
    issue(5'b10110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, MLAT, 1);
    issue(5'b10100, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, MLAT, 1);
    issue(5'b10101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, MLAT, 1);
    issue(5'b10111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, MLAT, 1);
    issue(5'b10101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, MLAT, 1);
    issue(5'b10111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, MLAT, 1);

    // Backpressure: hold out_ready low for 5 cycles in DONE while offering
    // a competing request that must not be accepted.
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    out_ready = 1'b0;
    issue(5'b00010, 32'h0000_000A, 32'h0000_0014, 32'h0000_001E, 1, 1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_in_ready_%0d", i), {31'b0, in_ready}, 32'd0);
      in_valid = 1'b1; op = 5'b00010; a = 32'h1; b = 32'h1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after", {31'b0, in_ready}, 32'd1);
    check("bp_out_valid_after", {31'b0, out_valid}, 32'd0);

    // Reset pulse during the 10th cycle of a DIVU aborts it.
    issue(5'b10101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, MLAT, 0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    check("abort_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_abort_in_ready", {31'b0, in_ready}, 32'd1);
    issue(5'b00010, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1, 1);

    // Drain the scoreboard.
    waited = 0;
    while (sb_q.size() != 0 && waited < 500) begin
      @(posedge clk);
      waited++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d responses still outstanding, expected 0", sb_q.size());
    end
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
